// File: rtl/copro_pkg.sv
// copro_pkg: shared definitions for the block-copy coprocessor sequencer.
//   copro_state_e : sequencer FSM state encoding
//   CFG_*         : bit positions of the config word fields (memory word 0)
//   ST_*          : bit positions of the status word fields (memory word 1)
package copro_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_READ    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_WRITE   = 3'd4,
    ST_FIN     = 3'd5
  } copro_state_e;

  // Config word layout
  localparam int CFG_START_BIT = 0;
  localparam int CFG_SRC_LSB   = 2;
  localparam int CFG_DST_LSB   = 12;
  localparam int CFG_ADDR_W    = 10;
  localparam int CFG_CNT_LSB   = 22;
  localparam int CFG_CNT_W     = 8;

  // Status word layout
  localparam int ST_BUSY_BIT = 0;
  localparam int ST_DONE_BIT = 1;
  localparam int ST_ERR_BIT  = 2;
  localparam int ST_PROG_LSB = 8;
  localparam int ST_PROG_W   = 8;

endpackage

// File: rtl/copro_range_check.sv
// copro_range_check: combinational legality check of a transfer request.
//   src, dst : block base word addresses from the config word
//   count    : number of blocks to copy
//   err      : 1 when the request must be refused (empty transfer, DST
//              overlapping the config/status words, or either span running
//              past the end of memory)
// Sums are formed in LOG_SIZE+2 bits so SRC/DST + BLOCKS*COUNT cannot wrap.
module copro_range_check
  import copro_pkg::*;
#(
  parameter int LOG_SIZE = 10,
  parameter int SIZE     = 1024,
  parameter int BLOCKS   = 4
) (
  input  logic [CFG_ADDR_W-1:0] src,
  input  logic [CFG_ADDR_W-1:0] dst,
  input  logic [CFG_CNT_W-1:0]  count,
  output logic                  err
);

  localparam int CW = LOG_SIZE + 2;

  logic [CW-1:0] span;
  logic [CW-1:0] src_end;
  logic [CW-1:0] dst_end;

  always_comb begin
    span    = CW'(BLOCKS) * CW'(count);
    src_end = CW'(src) + span;
    dst_end = CW'(dst) + span;
    err     = (count == '0) ||
              (dst < CFG_ADDR_W'(4)) ||
              (src_end > CW'(SIZE)) ||
              (dst_end > CW'(SIZE));
  end

endmodule

// File: rtl/copro_sequencer.sv
// copro_sequencer: memory-mapped block-copy coprocessor sequencer.
//   in_clk / in_reset   : single clock, synchronous active-high reset
//   in_config           : config word (START, SRC, DST, COUNT)
//   in_mem_data         : block read data, valid the cycle after out_read_en
//   out_address         : block base address for the current strobe
//   out_data            : block write data, zero unless out_write_en
//   out_read_en         : one-cycle block read strobe
//   out_write_en        : one-cycle block write strobe
//   out_status          : status word (BUSY, DONE, ERR, PROGRESS)
//   out_write_status_en : one-cycle status write strobe
//   out_dbg_state       : current FSM state
//   out_checksum        : sum of all written words (only when
//                         COPRO_SEQ_CHECKSUM_EN is defined)
//
// Memory strobe protocol: the memory has no back-pressure. Each strobe is a
// single-cycle pulse qualifying out_address (and out_data for writes) in that
// same cycle; read data is taken one cycle after the read strobe. Read and
// write strobes are never high together; the status strobe only coincides
// with the block write strobe.
//
// All outputs come from flops loaded on the transition into the state that
// owns them, so a state's strobes are visible exactly while in that state.
module copro_sequencer
  import copro_pkg::*;
#(
  parameter int LOG_SIZE   = 10,
  parameter int SIZE       = 1024,
  parameter int BLOCKS     = 4,
  parameter int CELL_WIDTH = 32,
  localparam int WIDTH     = BLOCKS * CELL_WIDTH
) (
  input  logic                  in_clk,
  input  logic                  in_reset,
  input  logic [CELL_WIDTH-1:0] in_config,
  input  logic [WIDTH-1:0]      in_mem_data,
  output logic [LOG_SIZE-1:0]   out_address,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_read_en,
  output logic                  out_write_en,
  output logic [CELL_WIDTH-1:0] out_status,
  output logic                  out_write_status_en,
  output copro_state_e          out_dbg_state
`ifdef COPRO_SEQ_CHECKSUM_EN
  ,
  output logic [CELL_WIDTH-1:0] out_checksum
`endif
);

  localparam logic [LOG_SIZE-1:0] BLK_STEP = LOG_SIZE'(BLOCKS);

  logic                  cfg_start;
  logic [CFG_ADDR_W-1:0] cfg_src;
  logic [CFG_ADDR_W-1:0] cfg_dst;
  logic [CFG_CNT_W-1:0]  cfg_cnt;
  logic                  range_err;
  logic                  unused_cfg;

  assign cfg_start  = in_config[CFG_START_BIT];
  assign cfg_src    = in_config[CFG_SRC_LSB +: CFG_ADDR_W];
  assign cfg_dst    = in_config[CFG_DST_LSB +: CFG_ADDR_W];
  assign cfg_cnt    = in_config[CFG_CNT_LSB +: CFG_CNT_W];
  assign unused_cfg = ^{in_config[1], in_config[CELL_WIDTH-1:CFG_CNT_LSB+CFG_CNT_W]};

  // Checked against the live config fields so the verdict is ready when the
  // CHECK status word is loaded on the trigger edge.
  copro_range_check #(
    .LOG_SIZE (LOG_SIZE),
    .SIZE     (SIZE),
    .BLOCKS   (BLOCKS)
  ) u_range_check (
    .src   (cfg_src),
    .dst   (cfg_dst),
    .count (cfg_cnt),
    .err   (range_err)
  );

  copro_state_e          state_q, state_d;
  logic                  prev_start_q, prev_start_d;
  logic [LOG_SIZE-1:0]   rd_addr_q, rd_addr_d;
  logic [LOG_SIZE-1:0]   wr_addr_q, wr_addr_d;
  logic [CFG_CNT_W-1:0]  count_q, count_d;
  logic [CFG_CNT_W-1:0]  idx_q, idx_d;
  logic                  err_q, err_d;
  logic [WIDTH-1:0]      buf_q, buf_d;
  logic [LOG_SIZE-1:0]   addr_q, addr_d;
  logic                  rd_en_q, rd_en_d;
  logic                  wr_en_q, wr_en_d;
  logic                  st_en_q, st_en_d;
  logic [CELL_WIDTH-1:0] status_q, status_d;
  logic [CFG_CNT_W-1:0]  idx_next;

  assign idx_next = idx_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    // START history is tracked in every state so an edge seen while busy is
    // consumed and cannot fire later.
    prev_start_d = cfg_start;
    rd_addr_d    = rd_addr_q;
    wr_addr_d    = wr_addr_q;
    count_d      = count_q;
    idx_d        = idx_q;
    err_d        = err_q;
    buf_d        = buf_q;
    addr_d       = '0;
    rd_en_d      = 1'b0;
    wr_en_d      = 1'b0;
    st_en_d      = 1'b0;
    status_d     = '0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start && !prev_start_q) begin
          state_d   = ST_CHECK;
          rd_addr_d = LOG_SIZE'(cfg_src);
          wr_addr_d = LOG_SIZE'(cfg_dst);
          count_d   = cfg_cnt;
          idx_d     = '0;
          err_d     = range_err;
          st_en_d   = 1'b1;
          if (range_err) begin
            status_d[ST_ERR_BIT]  = 1'b1;
            status_d[ST_DONE_BIT] = 1'b1;
          end else begin
            status_d[ST_BUSY_BIT] = 1'b1;
          end
        end
      end
      ST_CHECK: begin
        if (err_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_READ;
          rd_en_d = 1'b1;
          addr_d  = rd_addr_q;
        end
      end
      ST_READ: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d  = ST_WRITE;
        buf_d    = in_mem_data;
        wr_en_d  = 1'b1;
        addr_d   = wr_addr_q;
        st_en_d  = 1'b1;
        status_d[ST_BUSY_BIT] = 1'b1;
        status_d[ST_PROG_LSB +: ST_PROG_W] = idx_next;
      end
      ST_WRITE: begin
        idx_d     = idx_next;
        rd_addr_d = rd_addr_q + BLK_STEP;
        wr_addr_d = wr_addr_q + BLK_STEP;
        if (idx_next < count_q) begin
          state_d = ST_READ;
          rd_en_d = 1'b1;
          addr_d  = rd_addr_q + BLK_STEP;
        end else begin
          state_d = ST_FIN;
          st_en_d = 1'b1;
          status_d[ST_DONE_BIT] = 1'b1;
          status_d[ST_PROG_LSB +: ST_PROG_W] = count_q;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_q      <= ST_IDLE;
      prev_start_q <= 1'b0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      err_q        <= 1'b0;
      buf_q        <= '0;
      addr_q       <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      st_en_q      <= 1'b0;
      status_q     <= '0;
    end else begin
      state_q      <= state_d;
      prev_start_q <= prev_start_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_q    <= wr_addr_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      err_q        <= err_d;
      buf_q        <= buf_d;
      addr_q       <= addr_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      st_en_q      <= st_en_d;
      status_q     <= status_d;
    end
  end

  assign out_address         = addr_q;
  assign out_data            = wr_en_q ? buf_q : '0;
  assign out_read_en         = rd_en_q;
  assign out_write_en        = wr_en_q;
  assign out_status          = status_q;
  assign out_write_status_en = st_en_q;
  assign out_dbg_state       = state_q;

`ifdef COPRO_SEQ_CHECKSUM_EN
  logic [CELL_WIDTH-1:0] cks_q, cks_d, word_sum;

  // Cleared on entry to CHECK, accumulated on entry to WRITE (the block
  // being written is the one captured on that edge), held otherwise.
  always_comb begin
    word_sum = '0;
    for (int k = 0; k < BLOCKS; k++) begin
      word_sum = word_sum + in_mem_data[k*CELL_WIDTH +: CELL_WIDTH];
    end
    cks_d = cks_q;
    if (state_q == ST_IDLE && state_d == ST_CHECK) begin
      cks_d = '0;
    end else if (state_q == ST_CAPTURE) begin
      cks_d = cks_q + word_sum;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      cks_q <= '0;
    end else begin
      cks_q <= cks_d;
    end
  end

  assign out_checksum = cks_q;
`endif

endmodule

// File: tb/tb_copro_sequencer.sv
// tb_copro_sequencer: directed bench for copro_sequencer with a transfer-level
// reference model (golden memory image plus per-cycle expected timeline).
module tb_copro_sequencer;
  import copro_pkg::*;

  localparam int LOG_SIZE = 10;
  localparam int SIZE     = 1024;
  localparam int BLOCKS   = 4;
  localparam int CW       = 32;
  localparam int WIDTH    = BLOCKS * CW;

  logic                in_clk = 1'b0;
  logic                in_reset;
  logic [CW-1:0]       in_config;
  logic [WIDTH-1:0]    in_mem_data;
  logic [LOG_SIZE-1:0] out_address;
  logic [WIDTH-1:0]    out_data;
  logic                out_read_en;
  logic                out_write_en;
  logic [CW-1:0]       out_status;
  logic                out_write_status_en;
  copro_state_e        out_dbg_state;
`ifdef COPRO_SEQ_CHECKSUM_EN
  logic [CW-1:0]       out_checksum;
`endif

  copro_sequencer #(
    .LOG_SIZE   (LOG_SIZE),
    .SIZE       (SIZE),
    .BLOCKS     (BLOCKS),
    .CELL_WIDTH (CW)
  ) dut (
    .in_clk              (in_clk),
    .in_reset            (in_reset),
    .in_config           (in_config),
    .in_mem_data         (in_mem_data),
    .out_address         (out_address),
    .out_data            (out_data),
    .out_read_en         (out_read_en),
    .out_write_en        (out_write_en),
    .out_status          (out_status),
    .out_write_status_en (out_write_status_en),
    .out_dbg_state       (out_dbg_state)
`ifdef COPRO_SEQ_CHECKSUM_EN
    ,
    .out_checksum        (out_checksum)
`endif
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 in_clk = ~in_clk;

  int cyc = 0;
  initial forever begin
    @(posedge in_clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1);
  end

  // ---------------- memory and golden model ----------------
  logic [CW-1:0] mem  [SIZE];
  logic [CW-1:0] gold [SIZE];

  typedef struct {
    int              cyc;
    logic            rd;
    logic            wr;
    logic            st;
    logic [LOG_SIZE-1:0] addr;
    logic [WIDTH-1:0] data;
    logic [CW-1:0]   status;
    copro_state_e    state;
    logic [CW-1:0]   cks;
    logic            all_zero;
  } exp_t;

  exp_t exp_q[$];
  logic [CW-1:0] idle_cks = '0;
  bit cmp_on = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // per-test observation counters
  int n_rd, n_wr, n_st, busy_cyc;
  logic [CW-1:0] last_status;
  logic [LOG_SIZE-1:0] first_rd, first_wr;

  task automatic chk(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  function automatic exp_t mk(int c, copro_state_e s, logic [CW-1:0] k);
    exp_t e;
    e.cyc = c; e.rd = 1'b0; e.wr = 1'b0; e.st = 1'b0;
    e.addr = '0; e.data = '0; e.status = '0;
    e.state = s; e.cks = k; e.all_zero = 1'b0;
    return e;
  endfunction

  function automatic exp_t zero_rec(int c);
    exp_t e;
    e = mk(c, ST_IDLE, '0);
    e.all_zero = 1'b1;
    return e;
  endfunction

  function automatic logic [CW-1:0] make_cfg(logic start, int src, int dst, int n);
    logic [CW-1:0] c;
    c = '0;
    c[0]     = start;
    c[1]     = 1'b1;     // ignored bit
    c[11:2]  = 10'(src);
    c[21:12] = 10'(dst);
    c[29:22] = 8'(n);
    c[31:30] = 2'b11;    // ignored bits
    return c;
  endfunction

  // Expected timeline of one triggered transfer: CHECK at c0, then per block
  // READ/CAPTURE/WRITE, then FIN. Only the first nlim blocks update gold.
  task automatic push_xfer(int c0, int src, int dst, int n, int nlim);
    exp_t e;
    logic [WIDTH-1:0] blk;
    logic [CW-1:0] k;
    bit err;
    err = (n == 0) || (dst < 4) || (src + BLOCKS*n > SIZE) || (dst + BLOCKS*n > SIZE);
    k = '0;
    e = mk(c0, ST_CHECK, k);
    e.st = 1'b1;
    e.status = err ? 32'h0000_0006 : 32'h0000_0001;
    exp_q.push_back(e);
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        for (int w = 0; w < BLOCKS; w++) blk[w*CW +: CW] = gold[src + BLOCKS*i + w];
        if (i < nlim) begin
          for (int w = 0; w < BLOCKS; w++) gold[dst + BLOCKS*i + w] = blk[w*CW +: CW];
        end
        e = mk(c0 + 1 + 3*i, ST_READ, k);
        e.rd = 1'b1; e.addr = LOG_SIZE'(src + BLOCKS*i);
        exp_q.push_back(e);
        e = mk(c0 + 2 + 3*i, ST_CAPTURE, k);
        exp_q.push_back(e);
        for (int w = 0; w < BLOCKS; w++) k = k + blk[w*CW +: CW];
        e = mk(c0 + 3 + 3*i, ST_WRITE, k);
        e.wr = 1'b1; e.st = 1'b1; e.addr = LOG_SIZE'(dst + BLOCKS*i); e.data = blk;
        e.status = 32'(1 + (i + 1) * 256);
        exp_q.push_back(e);
      end
      e = mk(c0 + 3*n + 1, ST_FIN, k);
      e.st = 1'b1; e.status = 32'(2 + n * 256);
      exp_q.push_back(e);
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin
    logic [WIDTH-1:0] pend;
    logic pend_v;
    int a;
    pend = '0;
    pend_v = 1'b0;
    in_mem_data = '0;
    forever begin
      @(posedge in_clk); #1;
      if (pend_v) in_mem_data = pend;
      else for (int w = 0; w < BLOCKS; w++) in_mem_data[w*CW +: CW] = $urandom();
      pend_v = 1'b0;
      if (out_read_en === 1'b1) begin
        for (int w = 0; w < BLOCKS; w++) begin
          a = int'(out_address) + w;
          pend[w*CW +: CW] = mem[a];
        end
        pend_v = 1'b1;
      end
      if (out_write_en === 1'b1) begin
        for (int w = 0; w < BLOCKS; w++) begin
          a = int'(out_address) + w;
          mem[a] = out_data[w*CW +: CW];
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge in_clk);
      if (cmp_on) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) e = exp_q.pop_front();
        else e = mk(cyc, ST_IDLE, idle_cks);
        idle_cks = e.cks;
        chk("read_en", WIDTH'(out_read_en), WIDTH'(e.rd));
        chk("write_en", WIDTH'(out_write_en), WIDTH'(e.wr));
        chk("status_en", WIDTH'(out_write_status_en), WIDTH'(e.st));
        chk("data", out_data, e.data);
        chk("state", WIDTH'(out_dbg_state), WIDTH'(e.state));
        if (e.rd || e.wr || e.all_zero) chk("address", WIDTH'(out_address), WIDTH'(e.addr));
        if (e.st || e.all_zero) chk("status", WIDTH'(out_status), WIDTH'(e.status));
`ifdef COPRO_SEQ_CHECKSUM_EN
        chk("checksum", WIDTH'(out_checksum), WIDTH'(e.cks));
`endif
        if (out_read_en === 1'b1) begin
          n_rd++;
          if (n_rd == 1) first_rd = out_address;
        end
        if (out_write_en === 1'b1) begin
          n_wr++;
          if (n_wr == 1) first_wr = out_address;
        end
        if (out_write_status_en === 1'b1) begin
          n_st++;
          last_status = out_status;
        end
        if (out_dbg_state != ST_IDLE) busy_cyc++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_wait(int k);
    repeat (k) @(posedge in_clk);
    #1;
  endtask

  task automatic clr_mon();
    n_rd = 0; n_wr = 0; n_st = 0; busy_cyc = 0;
    last_status = '0; first_rd = '0; first_wr = '0;
  endtask

  task automatic drop_start();
    idle_wait(1);
    in_config = '0;
  endtask

  task automatic go(int src, int dst, int n, int nlim);
    idle_wait(1);
    in_config = make_cfg(1'b1, src, dst, n);
    push_xfer(cyc + 1, src, dst, n, nlim);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    in_reset  = 1'b1;
    in_config = '0;
    clr_mon();
    for (int i = 0; i < SIZE; i++) begin
      mem[i]  = 32'hC0DE_0000 + 32'(i);
      gold[i] = 32'hC0DE_0000 + 32'(i);
    end
    repeat (2) @(posedge in_clk);
    #1;
    exp_q.push_back(zero_rec(cyc));
    exp_q.push_back(zero_rec(cyc + 1));
    cmp_on   = 1'b1;
    in_reset = 1'b0;
    idle_wait(2);

    // basic two-block copy 16 -> 64
    clr_mon();
    go(16, 64, 2, 2);
    idle_wait(10);
    chk("t1 reads", WIDTH'(n_rd), WIDTH'(2));
    chk("t1 writes", WIDTH'(n_wr), WIDTH'(2));
    chk("t1 status writes", WIDTH'(n_st), WIDTH'(4));
    chk("t1 final status", WIDTH'(last_status), WIDTH'(32'h0000_0202));
    chk("t1 busy cycles", WIDTH'(busy_cyc), WIDTH'(8));
    chk("t1 first read addr", WIDTH'(first_rd), WIDTH'(16));
    chk("t1 first write addr", WIDTH'(first_wr), WIDTH'(64));
    chk("t1 mem64", WIDTH'(mem[64]), WIDTH'(32'hC0DE_0010));
    chk("t1 mem71", WIDTH'(mem[71]), WIDTH'(32'hC0DE_0017));

    // refused: COUNT=0, then DST=2
    drop_start(); clr_mon();
    go(32, 64, 0, 0);
    idle_wait(4);
    chk("t2a status writes", WIDTH'(n_st), WIDTH'(1));
    chk("t2a status", WIDTH'(last_status), WIDTH'(32'h0000_0006));
    chk("t2a mem strobes", WIDTH'(n_rd + n_wr), WIDTH'(0));
    drop_start(); clr_mon();
    go(32, 2, 1, 1);
    idle_wait(4);
    chk("t2b status", WIDTH'(last_status), WIDTH'(32'h0000_0006));
    chk("t2b mem strobes", WIDTH'(n_rd + n_wr), WIDTH'(0));
    chk("t2b busy cycles", WIDTH'(busy_cyc), WIDTH'(1));

    // source range boundary
    drop_start(); clr_mon();
    go(1020, 64, 2, 2);
    idle_wait(4);
    chk("t3a status", WIDTH'(last_status), WIDTH'(32'h0000_0006));
    chk("t3a reads", WIDTH'(n_rd), WIDTH'(0));
    drop_start(); clr_mon();
    go(1016, 100, 2, 2);
    idle_wait(10);
    chk("t3b status", WIDTH'(last_status), WIDTH'(32'h0000_0202));
    chk("t3b mem100", WIDTH'(mem[100]), WIDTH'(32'hC0DE_03F8));
    chk("t3b mem107", WIDTH'(mem[107]), WIDTH'(32'hC0DE_03FF));

    // START held; an edge during the transfer is ignored
    drop_start(); clr_mon();
    go(200, 300, 2, 2);
    idle_wait(2);
    in_config[0] = 1'b0;
    idle_wait(1);
    in_config[0] = 1'b1;
    idle_wait(20);
    chk("t4 one transfer status writes", WIDTH'(n_st), WIDTH'(4));
    chk("t4 busy cycles", WIDTH'(busy_cyc), WIDTH'(8));
    drop_start(); clr_mon();
    go(208, 308, 1, 1);
    idle_wait(8);
    chk("t4 retrigger status writes", WIDTH'(n_st), WIDTH'(3));
    chk("t4 retrigger status", WIDTH'(last_status), WIDTH'(32'h0000_0102));

    // overlapping ascending copy 400 -> 404
    drop_start(); clr_mon();
    go(400, 404, 3, 3);
    idle_wait(14);
    chk("t5 mem404", WIDTH'(mem[404]), WIDTH'(32'hC0DE_0190));
    chk("t5 mem408", WIDTH'(mem[408]), WIDTH'(32'hC0DE_0190));
    chk("t5 mem415", WIDTH'(mem[415]), WIDTH'(32'hC0DE_0193));
    chk("t5 status", WIDTH'(last_status), WIDTH'(32'h0000_0302));

    // reset during the second WRITE of a three-block copy
    drop_start(); clr_mon();
    go(500, 600, 3, 2);
    idle_wait(7);
    in_reset  = 1'b1;
    in_config = '0;
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > cyc) exp_q.delete(exp_q.size()-1);
    exp_q.push_back(zero_rec(cyc + 1));
    exp_q.push_back(zero_rec(cyc + 2));
    idle_wait(1);
    in_reset = 1'b0;
    idle_wait(8);
    chk("t6 writes", WIDTH'(n_wr), WIDTH'(2));
    chk("t6 state", WIDTH'(out_dbg_state), WIDTH'(ST_IDLE));
    chk("t6 mem604", WIDTH'(mem[604]), WIDTH'(32'hC0DE_01F8));
    chk("t6 mem608 untouched", WIDTH'(mem[608]), WIDTH'(32'hC0DE_0260));

    // START already high across a reset triggers exactly once
    go(700, 800, 1, 1);
    idle_wait(8);
    clr_mon();
    in_reset = 1'b1;
    exp_q.push_back(zero_rec(cyc + 1));
    idle_wait(1);
    in_reset = 1'b0;
    push_xfer(cyc + 1, 700, 800, 1, 1);
    idle_wait(12);
    chk("t7 status writes", WIDTH'(n_st), WIDTH'(3));
    chk("t7 status", WIDTH'(last_status), WIDTH'(32'h0000_0102));

    // checksum block 1,2,3,FFFFFFFF
    drop_start();
    mem[900] = 32'd1; mem[901] = 32'd2; mem[902] = 32'd3; mem[903] = 32'hFFFF_FFFF;
    for (int i = 900; i < 904; i++) gold[i] = mem[i];
    clr_mon();
    go(900, 920, 1, 1);
    idle_wait(8);
    chk("t8 mem923", WIDTH'(mem[923]), WIDTH'(32'hFFFF_FFFF));
`ifdef COPRO_SEQ_CHECKSUM_EN
    chk("t8 checksum", WIDTH'(out_checksum), WIDTH'(32'h0000_0005));
`endif

    // final image and model drain
    for (int i = 0; i < SIZE; i++) chk("mem image", WIDTH'(mem[i]), WIDTH'(gold[i]));
    chk("model queue drained", WIDTH'(exp_q.size()), WIDTH'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
